// File: rtl/gray_pos_tracker.sv
// Position tracker fed by a 3-bit gray-coded encoder: decodes, locks, counts +/-1 steps.
// Optional macro GRAY_ERR_CNT_EN adds a saturating illegal-transition counter (err_cnt).
module gray_pos_tracker #(
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       gray_in,
  input  logic             clr,
  output logic [2:0]       bin_out,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step_valid,
  output logic             locked,
  output logic             err,
`ifdef GRAY_ERR_CNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       bin_q, bin_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             dec_b2, dec_b1, dec_b0;
  logic [2:0]       dec;
  logic [2:0]       delta;

  assign dec_b2 = gray_in[2];
  assign dec_b1 = gray_in[1] ^ dec_b2;
  assign dec_b0 = gray_in[0] ^ dec_b1;
  assign dec    = {dec_b2, dec_b1, dec_b0};
  // Forward distance on the 8-position wheel; 1 = up one, 7 = down one.
  assign delta  = dec - prev_q;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    bin_d    = bin_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    locked_d = locked_q;
    err_d    = err_q;
    if (clr) begin
      state_d  = ST_IDLE;
      pos_d    = '0;
      err_d    = 1'b0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            prev_d   = dec;
            bin_d    = dec;
            state_d  = ST_TRACK;
            locked_d = 1'b1;
          end
        end
        ST_TRACK: begin
          if (in_valid) begin
            case (delta)
              3'd0: begin
                prev_d = dec;
                bin_d  = dec;
              end
              3'd1: begin
                prev_d = dec;
                bin_d  = dec;
                pos_d  = pos_q + POS_W'(1);
                dir_d  = 1'b1;
                step_d = 1'b1;
              end
              3'd7: begin
                prev_d = dec;
                bin_d  = dec;
                pos_d  = pos_q - POS_W'(1);
                dir_d  = 1'b0;
                step_d = 1'b1;
              end
              default: begin
                err_d    = 1'b1;
                state_d  = ST_FAULT;
                locked_d = 1'b0;
              end
            endcase
          end
        end
        ST_FAULT: begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      bin_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      bin_q    <= bin_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

`ifdef GRAY_ERR_CNT_EN
  logic       illegal;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Survives clr on purpose: only rst wipes the history of bad transitions.
  always_comb begin
    illegal   = !clr && in_valid && (state_q == ST_TRACK) &&
                (delta != 3'd0) && (delta != 3'd1) && (delta != 3'd7);
    err_cnt_d = err_cnt_q;
    if (illegal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign bin_out    = bin_q;
  assign pos        = pos_q;
  assign dir        = dir_q;
  assign step_valid = step_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Self-checking bench for gray_pos_tracker: behavioural model feeds an expected queue,
// outputs are popped and compared one cycle after each driven sample.
module tb_gray_pos_tracker;
  localparam int POS_W = 8;
  localparam int VW    = POS_W + 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [2:0]       gray_in;
  logic             clr;
  logic [2:0]       bin_out;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic             step_valid;
  logic             locked;
  logic             err;
  logic [1:0]       state_dbg;
`ifdef GRAY_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  gray_pos_tracker #(.POS_W(POS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .gray_in    (gray_in),
    .clr        (clr),
    .bin_out    (bin_out),
    .pos        (pos),
    .dir        (dir),
    .step_valid (step_valid),
    .locked     (locked),
    .err        (err),
`ifdef GRAY_ERR_CNT_EN
    .err_cnt    (err_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] exp_q[$];

  // reference model state
  int               m_state;
  logic [2:0]       m_prev, m_bin;
  logic [POS_W-1:0] m_pos;
  logic             m_dir, m_sv, m_lock, m_err;

  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    for (int i = 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [2:0] b2g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bin_out, pos, dir, step_valid, locked, err, state_dbg};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_bin, m_pos, m_dir, m_sv, m_lock, m_err, 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = '0; m_bin = '0; m_pos = '0;
    m_dir = 0; m_sv = 0; m_lock = 0; m_err = 0;
    exp_q.delete();
  endtask

  // Drive one sample mid-cycle and queue the outputs expected after the next edge.
  task automatic apply(input logic v, input logic c, input logic [2:0] g);
    logic [2:0] b, d;
    in_valid = v; clr = c; gray_in = g;
    b = g2b(g);
    m_sv = 0;
    if (c) begin
      m_state = 0; m_pos = '0; m_err = 0; m_lock = 0;
    end else if (v) begin
      if (m_state == 0) begin
        m_prev = b; m_bin = b; m_state = 1; m_lock = 1;
      end else if (m_state == 1) begin
        d = b - m_prev;
        if (d == 3'd0 || d == 3'd1 || d == 3'd7) begin
          m_prev = b; m_bin = b;
          if (d == 3'd1) begin m_pos = m_pos + 1'b1; m_dir = 1; m_sv = 1; end
          if (d == 3'd7) begin m_pos = m_pos - 1'b1; m_dir = 0; m_sv = 1; end
        end else begin
          m_err = 1; m_state = 2; m_lock = 0;
        end
      end
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic sync_reset_pulse();
    rst = 1'b1; in_valid = 0; clr = 0; gray_in = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] got, exp_v;
    rst = 1'b1; in_valid = 0; clr = 0; gray_in = '0;
    model_reset();
    #2;
    got = obs_vec(); exp_v = model_vec();
    n_cmp++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL reset_state: got %h exp %h", got, exp_v);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs a stimulus list ({valid, clr, gray}) and checks every cycle.
  task automatic test_basic_up();
    logic [4:0] seq [4] = '{5'b10_000, 5'b10_001, 5'b10_011, 5'b10_010};
    logic [VW-1:0] got, exp_v;
    int pulses = 0;
    sync_reset_pulse();
    for (int i = 0; i < 4; i++) begin
      apply(seq[i][4], seq[i][3], seq[i][2:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL basic_up cyc %0d: got %h exp %h", i, got, exp_v);
      end
      if (step_valid === 1'b1) pulses++;
    end
    apply(0, 0, 3'b010);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    n_cmp++;
    if (pulses != 3 || pos !== POS_W'(3) || bin_out !== 3'd3 || dir !== 1'b1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL basic_up_final: pulses %0d pos %0d bin %0d dir %b lock %b exp 3/3/3/1/1",
               pulses, pos, bin_out, dir, locked);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] seq [6] = '{5'b01_000, 5'b10_000, 5'b10_100, 5'b10_000, 5'b10_100, 5'b10_101};
    logic [VW-1:0] got, exp_v;
    for (int i = 0; i < 6; i++) begin
      apply(seq[i][4], seq[i][3], seq[i][2:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL wrap cyc %0d: got %h exp %h", i, got, exp_v);
      end
      if (i == 2) begin
        n_cmp++;
        if (pos !== {POS_W{1'b1}} || dir !== 1'b0 || step_valid !== 1'b1) begin
          n_err++; $display("FAIL wrap_down: pos %0d dir %b sv %b exp all-ones/0/1", pos, dir, step_valid);
        end
      end
    end
  endtask

  task automatic test_fault();
    logic [4:0] seq [8] = '{5'b01_000, 5'b10_001, 5'b10_110, 5'b10_011, 5'b10_001,
                            5'b00_000, 5'b01_000, 5'b10_011};
    logic [VW-1:0] got, exp_v;
    for (int i = 0; i < 8; i++) begin
      apply(seq[i][4], seq[i][3], seq[i][2:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL fault cyc %0d: got %h exp %h", i, got, exp_v);
      end
      if (i == 4) begin
        n_cmp++;
        if (err !== 1'b1 || locked !== 1'b0 || bin_out !== 3'd1 || state_dbg !== 2'd2) begin
          n_err++; $display("FAIL fault_hold: err %b lock %b bin %0d st %0d exp 1/0/1/2",
                            err, locked, bin_out, state_dbg);
        end
      end
    end
  endtask

  task automatic test_clr_priority();
    logic [4:0] seq [6] = '{5'b01_000, 5'b10_000, 5'b10_001, 5'b11_011, 5'b00_011, 5'b10_011};
    logic [VW-1:0] got, exp_v;
    for (int i = 0; i < 6; i++) begin
      apply(seq[i][4], seq[i][3], seq[i][2:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL clr_priority cyc %0d: got %h exp %h", i, got, exp_v);
      end
      if (i == 3) begin
        n_cmp++;
        if (pos !== '0 || step_valid !== 1'b0 || state_dbg !== 2'd0 || bin_out !== 3'd1) begin
          n_err++; $display("FAIL clr_discard: pos %0d sv %b st %0d bin %0d exp 0/0/0/1",
                            pos, step_valid, state_dbg, bin_out);
        end
      end
    end
  endtask

  task automatic test_no_valid();
    logic [4:0] seq [5] = '{5'b00_010, 5'b00_110, 5'b00_111, 5'b00_000, 5'b10_010};
    logic [VW-1:0] got, exp_v;
    for (int i = 0; i < 5; i++) begin
      apply(seq[i][4], seq[i][3], seq[i][2:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL no_valid cyc %0d: got %h exp %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] seq [7] = '{5'b01_000, 5'b10_000, 5'b10_001, 5'b10_011, 5'b10_010,
                            5'b10_110, 5'b10_111};
    logic [VW-1:0] got, exp_v;
    for (int i = 0; i < 7; i++) begin
      apply(seq[i][4], seq[i][3], seq[i][2:0]);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL async_pre cyc %0d: got %h exp %h", i, got, exp_v);
      end
    end
    n_cmp++;
    if (pos !== POS_W'(5)) begin
      n_err++; $display("FAIL async_pos5: got %0d exp 5", pos);
    end
    in_valid = 0;
    rst = 1'b1;
    #2;
    got = obs_vec(); n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL async_now: got %h exp 0", got);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    apply(1, 0, 3'b101);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
    if (got !== exp_v || pos !== '0 || locked !== 1'b1) begin
      n_err++; $display("FAIL async_relock: got %h exp %h", got, exp_v);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp_v;
    logic [2:0] b;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      b = m_prev + 3'd1;
      else if (sel < 7) b = m_prev - 3'd1;
      else if (sel < 8) b = m_prev;
      else              b = 3'($urandom_range(0, 7));
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, b2g(b));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); got = obs_vec(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL random cyc %0d: got %h exp %h", i, got, exp_v);
      end
    end
  endtask

`ifdef GRAY_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [VW-1:0] got, exp_v;
    int bad = 0;
    sync_reset_pulse();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 0)      apply(0, 1, 3'b000);
        else if (k == 1) apply(1, 0, 3'b000);
        else             apply(1, 0, 3'b110);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front(); got = obs_vec();
        if (got !== exp_v) bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL err_cnt_seq: %0d cycles got wrong outputs, exp 0", bad);
    end
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_err++; $display("FAIL err_cnt_sat: got %0d exp 255", err_cnt);
    end
    apply(0, 1, 3'b000);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_err++; $display("FAIL err_cnt_clr: got %0d exp 255", err_cnt);
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (err_cnt !== 8'd0) begin
      n_err++; $display("FAIL err_cnt_rst: got %0d exp 0", err_cnt);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
`endif

  initial begin
    in_valid = 0; clr = 0; gray_in = '0; rst = 1'b1;
    test_reset();
    test_basic_up();
    test_wrap();
    test_fault();
    test_clr_priority();
    test_no_valid();
    test_async_reset();
    test_random();
`ifdef GRAY_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
